// File: rtl/pcie_us_cq_cc_reg_completer.sv
// Single-DW BAR register completer for the UltraScale CQ/CC AXI-stream interfaces.
// Serves 1-DW memory reads/writes to a small register file; other non-posted requests get UR.
module pcie_us_cq_cc_reg_completer #(
  parameter int DATA_WIDTH     = 64,
  parameter int KEEP_WIDTH     = DATA_WIDTH/32,
  parameter int CQ_USER_WIDTH  = 85,
  parameter int CC_USER_WIDTH  = 33,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                     user_clk,
  input  logic                     user_reset_n,
  input  logic [DATA_WIDTH-1:0]    m_axis_cq_tdata,
  input  logic [KEEP_WIDTH-1:0]    m_axis_cq_tkeep,
  input  logic                     m_axis_cq_tlast,
  output logic                     m_axis_cq_tready,
  input  logic [CQ_USER_WIDTH-1:0] m_axis_cq_tuser,
  input  logic                     m_axis_cq_tvalid,
  output logic [DATA_WIDTH-1:0]    s_axis_cc_tdata,
  output logic [KEEP_WIDTH-1:0]    s_axis_cc_tkeep,
  output logic                     s_axis_cc_tlast,
  input  logic [3:0]               s_axis_cc_tready,
  output logic [CC_USER_WIDTH-1:0] s_axis_cc_tuser,
  output logic                     s_axis_cc_tvalid,
  output logic [15:0]              stat_ur_count
);
  localparam int NREG = 2**REG_ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, HDR1, WDATA, DROP, CPL0, CPL1} state_t;

  state_t      state;
  logic        cq_rdy;
  logic [61:0] addr_q;
  logic [3:0]  be_q;
  logic [15:0] rid_q;
  logic [7:0]  tag_q;
  logic [2:0]  tc_q, attr_q;
  logic        ur_q, drop_cpl;
  logic [31:0] regs [NREG];

  logic        beat;
  logic        cc_go;
  logic [10:0] h_cnt;
  logic [3:0]  h_type;
  logic [15:0] h_rid;
  logic        h_posted, h_sc_rd, h_wr;
  logic [15:0] ur_inc;
  logic [REG_ADDR_WIDTH-1:0] idx;

  assign beat     = m_axis_cq_tvalid && cq_rdy;
  assign cc_go    = s_axis_cc_tready[0];
  assign h_cnt    = m_axis_cq_tdata[10:0];
  assign h_type   = m_axis_cq_tdata[14:11];
  assign h_rid    = m_axis_cq_tdata[31:16];
  // Memory write and the three message types are the only posted requests.
  assign h_posted = h_type inside {4'b0001, 4'b1100, 4'b1101, 4'b1110};
  assign h_sc_rd  = (h_type == 4'b0000) && (h_cnt == 11'd1) && m_axis_cq_tlast;
  assign h_wr     = (h_type == 4'b0001) && (h_cnt == 11'd1) && !m_axis_cq_tlast;
  assign ur_inc   = (stat_ur_count == 16'hFFFF) ? stat_ur_count : stat_ur_count + 16'd1;
  assign idx      = addr_q[REG_ADDR_WIDTH-1:0];

  assign m_axis_cq_tready = cq_rdy;
  assign s_axis_cc_tuser  = '0;

  logic unused_ok;
  assign unused_ok = ^{m_axis_cq_tkeep, m_axis_cq_tuser[CQ_USER_WIDTH-1:4],
                       s_axis_cc_tready[3:1], addr_q[61:5]};

  // Completion descriptor DW1:DW0
  function automatic logic [63:0] cpl0_beat(input logic [4:0] a, input logic ur,
                                            input logic [15:0] rid);
    logic [31:0] dw0, dw1;
    dw0        = '0;
    dw0[6:0]   = {a, 2'b00};
    dw0[28:16] = ur ? 13'd0 : 13'd4;
    dw1        = '0;
    dw1[10:0]  = ur ? 11'd0 : 11'd1;
    dw1[13:11] = ur ? 3'b001 : 3'b000;
    dw1[31:16] = rid;
    return {dw1, dw0};
  endfunction

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state            <= IDLE;
      cq_rdy           <= 1'b0;
      addr_q           <= '0;
      be_q             <= '0;
      rid_q            <= '0;
      tag_q            <= '0;
      tc_q             <= '0;
      attr_q           <= '0;
      ur_q             <= 1'b0;
      drop_cpl         <= 1'b0;
      s_axis_cc_tdata  <= '0;
      s_axis_cc_tkeep  <= '0;
      s_axis_cc_tlast  <= 1'b0;
      s_axis_cc_tvalid <= 1'b0;
      stat_ur_count    <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          cq_rdy <= 1'b1;
          if (beat) begin
            addr_q <= m_axis_cq_tdata[63:2];
            be_q   <= m_axis_cq_tuser[3:0];
            state  <= HDR1;
          end
        end
        HDR1: if (beat) begin
          rid_q  <= h_rid;
          tag_q  <= m_axis_cq_tdata[39:32];
          tc_q   <= m_axis_cq_tdata[59:57];
          attr_q <= m_axis_cq_tdata[62:60];
          if (h_sc_rd) begin
            ur_q             <= 1'b0;
            s_axis_cc_tdata  <= cpl0_beat(addr_q[4:0], 1'b0, h_rid);
            s_axis_cc_tkeep  <= KEEP_WIDTH'(2'b11);
            s_axis_cc_tlast  <= 1'b0;
            s_axis_cc_tvalid <= 1'b1;
            cq_rdy           <= 1'b0;
            state            <= CPL0;
          end else if (h_wr) begin
            state <= WDATA;
          end else begin
            stat_ur_count <= ur_inc;
            drop_cpl      <= !h_posted;
            if (!h_posted) begin
              ur_q <= 1'b1;
              if (m_axis_cq_tlast) begin
                s_axis_cc_tdata  <= cpl0_beat(addr_q[4:0], 1'b1, h_rid);
                s_axis_cc_tkeep  <= KEEP_WIDTH'(2'b11);
                s_axis_cc_tlast  <= 1'b0;
                s_axis_cc_tvalid <= 1'b1;
                cq_rdy           <= 1'b0;
                state            <= CPL0;
              end else begin
                state <= DROP;
              end
            end else begin
              state <= m_axis_cq_tlast ? IDLE : DROP;
            end
          end
        end
        WDATA: if (beat) begin
          for (int b = 0; b < 4; b++)
            if (be_q[b]) regs[idx][8*b +: 8] <= m_axis_cq_tdata[8*b +: 8];
          drop_cpl <= 1'b0;
          state    <= m_axis_cq_tlast ? IDLE : DROP;
        end
        DROP: if (beat && m_axis_cq_tlast) begin
          if (drop_cpl) begin
            s_axis_cc_tdata  <= cpl0_beat(addr_q[4:0], 1'b1, rid_q);
            s_axis_cc_tkeep  <= KEEP_WIDTH'(2'b11);
            s_axis_cc_tlast  <= 1'b0;
            s_axis_cc_tvalid <= 1'b1;
            cq_rdy           <= 1'b0;
            state            <= CPL0;
          end else begin
            state <= IDLE;
          end
        end
        CPL0: if (cc_go) begin
          // DW3:DW2 -- completer ID left zero, data only on successful reads
          s_axis_cc_tdata  <= {(ur_q ? 32'h0 : regs[idx]),
                               1'b0, attr_q, tc_q, 1'b0, 16'h0000, tag_q};
          s_axis_cc_tkeep  <= ur_q ? KEEP_WIDTH'(2'b01) : KEEP_WIDTH'(2'b11);
          s_axis_cc_tlast  <= 1'b1;
          state            <= CPL1;
        end
        CPL1: if (cc_go) begin
          s_axis_cc_tvalid <= 1'b0;
          s_axis_cc_tlast  <= 1'b0;
          cq_rdy           <= 1'b1;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pcie_us_cq_cc_reg_completer.sv
// Scoreboard bench for the CQ/CC register completer: a register model predicts every CC beat.
module tb_pcie_us_cq_cc_reg_completer;
  logic        user_clk = 1'b0;
  logic        user_reset_n = 1'b0;
  logic [63:0] cq_tdata = '0;
  logic [1:0]  cq_tkeep = 2'b11;
  logic        cq_tlast = 1'b0;
  logic        cq_tready;
  logic [84:0] cq_tuser = '0;
  logic        cq_tvalid = 1'b0;
  logic [63:0] cc_tdata;
  logic [1:0]  cc_tkeep;
  logic        cc_tlast;
  logic [3:0]  cc_tready = 4'b0001;
  logic [32:0] cc_tuser;
  logic        cc_tvalid;
  logic [15:0] stat_ur_count;

  pcie_us_cq_cc_reg_completer dut (
    .user_clk(user_clk), .user_reset_n(user_reset_n),
    .m_axis_cq_tdata(cq_tdata), .m_axis_cq_tkeep(cq_tkeep), .m_axis_cq_tlast(cq_tlast),
    .m_axis_cq_tready(cq_tready), .m_axis_cq_tuser(cq_tuser), .m_axis_cq_tvalid(cq_tvalid),
    .s_axis_cc_tdata(cc_tdata), .s_axis_cc_tkeep(cc_tkeep), .s_axis_cc_tlast(cc_tlast),
    .s_axis_cc_tready(cc_tready), .s_axis_cc_tuser(cc_tuser), .s_axis_cc_tvalid(cc_tvalid),
    .stat_ur_count(stat_ur_count)
  );

  always #5 user_clk = ~user_clk;

  typedef struct packed {logic [1:0] keep; logic last; logic [63:0] data;} beat_t;
  beat_t       exp_q[$];
  logic [31:0] model [16];
  int          tests = 0, fails = 0, cc_beats = 0;
  logic [15:0] ur_exp = 0;

  always @(negedge user_clk) begin
    if (cc_tvalid && cc_tready[0]) begin
      beat_t e;
      cc_beats++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL cc_unexpected got keep=%b last=%b data=%h", cc_tkeep, cc_tlast, cc_tdata);
      end else begin
        e = exp_q.pop_front();
        if ({cc_tkeep, cc_tlast, cc_tdata} !== e || cc_tuser !== 33'h0) begin
          fails++;
          $display("FAIL cc_beat got keep=%b last=%b data=%h user=%h exp keep=%b last=%b data=%h user=0",
                   cc_tkeep, cc_tlast, cc_tdata, cc_tuser, e.keep, e.last, e.data);
        end
      end
    end
  end

  task automatic push_cpl(input logic [63:0] addr, input logic ur, input logic [15:0] rid,
                          input logic [7:0] tag, input logic [2:0] tc, input logic [2:0] attr,
                          input logic [31:0] data);
    logic [31:0] dw0, dw1, dw2, dw3;
    dw0 = {3'b000, (ur ? 13'd0 : 13'd4), 6'b0, 2'b00, 1'b0, addr[6:2], 2'b00};
    dw1 = {rid, 1'b0, 1'b0, (ur ? 3'b001 : 3'b000), (ur ? 11'd0 : 11'd1)};
    dw2 = {1'b0, attr, tc, 1'b0, 16'h0000, tag};
    dw3 = ur ? 32'h0 : data;
    exp_q.push_back({2'b11, 1'b0, dw1, dw0});
    exp_q.push_back({(ur ? 2'b01 : 2'b11), 1'b1, dw3, dw2});
  endtask

  task automatic cq_beat(input logic [63:0] d, input logic [3:0] be, input logic last);
    int n = 0;
    @(negedge user_clk);
    cq_tvalid = 1'b1; cq_tdata = d; cq_tuser = '0; cq_tuser[3:0] = be; cq_tlast = last;
    while (cq_tready !== 1'b1 && n < 200) begin @(negedge user_clk); n++; end
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL cq_ready_timeout got tready=%b exp 1", cq_tready);
    end
    @(posedge user_clk);
  endtask

  // Returns on the falling edge right after the final beat is accepted.
  task automatic cq_req(input logic [63:0] addr, input logic [3:0] be, input logic [3:0] typ,
                        input logic [10:0] cnt, input logic [15:0] rid, input logic [7:0] tag,
                        input logic [2:0] tc, input logic [2:0] attr, input int ndata,
                        input logic [31:0] wdata);
    cq_beat({addr[63:2], 2'b00}, be, ndata == 0);
    cq_beat({1'b0, attr, tc, 17'h0, tag, rid, 1'b0, typ, cnt}, be, ndata == 0);
    for (int i = 0; i < ndata; i++)
      cq_beat((i == 0) ? {32'h0, wdata} : {$urandom, $urandom}, be, i == ndata - 1);
    @(negedge user_clk);
    cq_tvalid = 1'b0; cq_tlast = 1'b0;
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [3:0] be, input logic [31:0] d);
    for (int b = 0; b < 4; b++) if (be[b]) model[addr[5:2]][8*b +: 8] = d[8*b +: 8];
    cq_req(addr, be, 4'h1, 11'd1, 16'h0, 8'h0, 3'd0, 3'd0, 1, d);
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [15:0] rid, input logic [7:0] tag,
                         input logic [2:0] tc, input logic [2:0] attr);
    push_cpl(addr, 1'b0, rid, tag, tc, attr, model[addr[5:2]]);
    cq_req(addr, 4'hF, 4'h0, 11'd1, rid, tag, tc, attr, 0, 32'h0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge user_clk); n++; end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain got %0d pending beats exp 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_stat(input string name);
    tests++;
    if (stat_ur_count !== ur_exp) begin
      fails++;
      $display("FAIL %s_stat got %0d exp %0d", name, stat_ur_count, ur_exp);
    end
  endtask

  task automatic test_reset;
    @(negedge user_clk);
    tests++;
    if ({cq_tready, cc_tvalid, cc_tlast, cc_tdata, cc_tkeep, cc_tuser, stat_ur_count} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got tready=%b valid=%b last=%b data=%h keep=%b stat=%0d exp all 0",
               cq_tready, cc_tvalid, cc_tlast, cc_tdata, cc_tkeep, stat_ur_count);
    end
    user_reset_n = 1'b1;
    repeat (2) @(negedge user_clk);
    tests++;
    if (cq_tready !== 1'b1) begin
      fails++;
      $display("FAIL reset_idle_ready got %b exp 1", cq_tready);
    end
  endtask

  task automatic test_write_read;
    do_write(64'h8, 4'hF, 32'hDEADBEEF);
    do_read(64'h8, 16'h0100, 8'h12, 3'd0, 3'd0);
    tests++;
    if (cc_tvalid !== 1'b1 || cq_tready !== 1'b0) begin
      fails++;
      $display("FAIL rd_latency got valid=%b cq_ready=%b exp valid=1 cq_ready=0", cc_tvalid, cq_tready);
    end
    drain("write_read");
  endtask

  task automatic test_byte_enables;
    do_write(64'hC, 4'hF, 32'h11223344);
    do_write(64'hC, 4'h5, 32'hAABBCCDD);
    tests++;
    if (model[3] !== 32'h11BB33DD) begin
      fails++;
      $display("FAIL be_model got %h exp 11bb33dd", model[3]);
    end
    do_read(64'hC, 16'h0203, 8'h34, 3'd1, 3'd2);
    drain("byte_enables");
  endtask

  task automatic test_alias;
    do_write(64'h48, 4'hF, 32'h55);
    do_read(64'h8, 16'h0100, 8'h21, 3'd0, 3'd0);
    drain("alias");
  endtask

  task automatic test_ur;
    int beats0;
    push_cpl(64'h10, 1'b1, 16'h0A0B, 8'h40, 3'd3, 3'd1, 32'h0);
    cq_req(64'h10, 4'hF, 4'h0, 11'd2, 16'h0A0B, 8'h40, 3'd3, 3'd1, 0, 32'h0);
    ur_exp++;
    drain("ur_rd2");
    check_stat("ur_rd2");
    push_cpl(64'h24, 1'b1, 16'h0C0D, 8'h41, 3'd0, 3'd0, 32'h0);
    cq_req(64'h24, 4'hF, 4'h2, 11'd1, 16'h0C0D, 8'h41, 3'd0, 3'd0, 0, 32'h0);
    ur_exp++;
    drain("ur_io_rd");
    check_stat("ur_io_rd");
    // non-posted request carrying data: payload dropped, then UR
    push_cpl(64'h4, 1'b1, 16'h0E0F, 8'h42, 3'd0, 3'd0, 32'h0);
    cq_req(64'h4, 4'hF, 4'h3, 11'd1, 16'h0E0F, 8'h42, 3'd0, 3'd0, 1, 32'h12345678);
    ur_exp++;
    drain("ur_io_wr");
    check_stat("ur_io_wr");
    beats0 = cc_beats;
    cq_req(64'h0, 4'hF, 4'hC, 11'd2, 16'h0, 8'h0, 3'd0, 3'd0, 2, 32'h9);
    cq_req(64'h8, 4'hF, 4'h1, 11'd2, 16'h0, 8'h0, 3'd0, 3'd0, 2, 32'hBAD0BAD0);
    ur_exp += 2;
    repeat (4) @(negedge user_clk);
    check_stat("ur_posted");
    tests++;
    if (cc_beats != beats0) begin
      fails++;
      $display("FAIL ur_posted_no_cpl got %0d beats exp 0", cc_beats - beats0);
    end
    // 1-DW write with trailing junk beat still commits the first DW
    model[1] = 32'hCAFEF00D;
    cq_req(64'h4, 4'hF, 4'h1, 11'd1, 16'h0, 8'h0, 3'd0, 3'd0, 2, 32'hCAFEF00D);
    check_stat("wr_extra_beat");
    do_read(64'h8, 16'h0100, 8'h43, 3'd0, 3'd0);
    do_read(64'h4, 16'h0100, 8'h44, 3'd0, 3'd0);
    drain("ur_after");
  endtask

  task automatic test_backpressure;
    int beats0 = cc_beats;
    cc_tready = 4'b0000;
    do_read(64'h8, 16'h0777, 8'h66, 3'd5, 3'd3);
    for (int p = 0; p < 2; p++) begin
      repeat (5) begin
        tests++;
        if (cc_tvalid !== 1'b1 || cq_tready !== 1'b0 || cc_tdata !== exp_q[0].data
            || cc_tlast !== exp_q[0].last) begin
          fails++;
          $display("FAIL bp_hold%0d got valid=%b cq_ready=%b last=%b data=%h exp valid=1 cq_ready=0 last=%b data=%h",
                   p, cc_tvalid, cq_tready, cc_tlast, cc_tdata, exp_q[0].last, exp_q[0].data);
        end
        @(negedge user_clk);
      end
      @(posedge user_clk); #1 cc_tready = 4'b0001;
      @(posedge user_clk); #1 cc_tready = (p == 0) ? 4'b0000 : 4'b0001;
      @(negedge user_clk);
    end
    drain("backpressure");
    tests++;
    if (cc_beats - beats0 != 2) begin
      fails++;
      $display("FAIL bp_beats got %0d exp 2", cc_beats - beats0);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 24; i++) begin
      logic [63:0] a;
      a = {$urandom, 26'($urandom), 4'($urandom), 2'b00};
      cc_tready = {3'($urandom), 1'b1};
      if ($urandom_range(0, 1) == 0) do_write(a, 4'($urandom), $urandom);
      else do_read(a, 16'($urandom), 8'($urandom), 3'($urandom), 3'($urandom));
    end
    drain("back_to_back");
    cc_tready = 4'b0001;
  endtask

  task automatic test_reset_mid;
    int n = 0;
    do_write(64'h8, 4'hF, 32'h600DF00D);
    do_read(64'h8, 16'h0100, 8'h77, 3'd0, 3'd0);
    while (!(cc_tvalid && !cc_tlast) && n < 50) begin @(negedge user_clk); n++; end
    @(posedge user_clk); #1 cc_tready = 4'b0000;
    @(negedge user_clk);
    tests++;
    if (cc_tvalid !== 1'b1 || cc_tlast !== 1'b1) begin
      fails++;
      $display("FAIL rst_in_cpl1 got valid=%b last=%b exp 1 1", cc_tvalid, cc_tlast);
    end
    user_reset_n = 1'b0;
    #1;
    tests++;
    if (cc_tvalid !== 1'b0 || cq_tready !== 1'b0 || stat_ur_count !== 16'h0) begin
      fails++;
      $display("FAIL rst_async got valid=%b cq_ready=%b stat=%0d exp 0 0 0", cc_tvalid, cq_tready, stat_ur_count);
    end
    exp_q.delete();
    for (int r = 0; r < 16; r++) model[r] = 32'h0;
    ur_exp = 0;
    @(negedge user_clk);
    user_reset_n = 1'b1;
    @(posedge user_clk); #1 cc_tready = 4'b0001;
    do_read(64'h8, 16'h0ABC, 8'h5A, 3'd2, 3'd1);
    do_read(64'hC, 16'h0ABC, 8'h5B, 3'd0, 3'd0);
    drain("reset_mid");
    check_stat("reset_mid");
  endtask

  initial begin
    for (int r = 0; r < 16; r++) model[r] = 32'h0;
    test_reset();
    test_write_read();
    test_byte_enables();
    test_alias();
    test_ur();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
